// File: rtl/jedro_1_mem_pkg.sv
// Shared types and constants for the jedro_1 instruction/data memory arbiter.
// Owner tags identify which requester a RAM response belongs to.
package jedro_1_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    localparam int RAM_LATENCY_MIN = 1;
    localparam int RAM_LATENCY_MAX = 3;

    // Bit positions of each requester inside the 2-bit req/gnt vectors
    localparam int REQ_INSTR = 0;
    localparam int REQ_DATA  = 1;

    function automatic owner_e owner_of(input logic [1:0] gnt);
        owner_e own;
        own = OWN_NONE;
        if (gnt[REQ_DATA]) begin
            own = OWN_DATA;
        end else if (gnt[REQ_INSTR]) begin
            own = OWN_INSTR;
        end
        return own;
    endfunction

endpackage

// File: rtl/jedro_1_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advanced only when
// both sides compete so a lone requester never disturbs the fairness history.
module jedro_1_rr_arb2
    import jedro_1_mem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_data_q;
    logic last_data_d;

    always_comb begin
        gnt_o       = 2'b00;
        last_data_d = last_data_q;
        if (req_i == 2'b11) begin
            if (last_data_q) begin
                gnt_o[REQ_INSTR] = 1'b1;
            end else begin
                gnt_o[REQ_DATA] = 1'b1;
            end
            last_data_d = ~last_data_q;
        end else begin
            gnt_o = req_i;
        end
    end

    // Reset value "instr won last" hands the first tie to data
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data ports; an
// owner-tag pipeline matched to the RAM latency routes each response back.
module jedro_1_mem_arbiter
    import jedro_1_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    ram_en_o,
    output logic [DATA_WIDTH/8-1:0] ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    if (RAM_LATENCY < RAM_LATENCY_MIN || RAM_LATENCY > RAM_LATENCY_MAX) begin : g_bad_latency
        $error("jedro_1_mem_arbiter: RAM_LATENCY=%0d outside legal range 1..3", RAM_LATENCY);
    end

    logic [1:0] req;
    logic [1:0] gnt;
    owner_e     grant_owner;
    owner_e     tag_out;
    owner_e     tag_q [RAM_LATENCY];
    owner_e     tag_d [RAM_LATENCY];

    // Grants are combinational, so reset must mask requests directly
    assign req = {data_req_i, instr_req_i} & {2{rstn_i}};

    jedro_1_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (req),
        .gnt_o  (gnt)
    );

    assign instr_gnt_o = gnt[REQ_INSTR];
    assign data_gnt_o  = gnt[REQ_DATA];
    assign ram_en_o    = gnt[REQ_INSTR] | gnt[REQ_DATA];
    assign grant_owner = owner_of(gnt);

    always_comb begin
        ram_addr_o  = instr_addr_i;
        ram_wdata_o = data_wdata_i;
        ram_we_o    = '0;
        if (gnt[REQ_DATA]) begin
            ram_addr_o = data_addr_i;
            if (data_we_i) begin
                ram_we_o = data_be_i;
            end
        end
    end

    always_comb begin
        tag_d[0] = grant_owner;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Clearing the tags on reset drops any access still in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_q[i] <= OWN_NONE;
            end
        end else begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tag_out        = tag_q[RAM_LATENCY-1];
    assign instr_rvalid_o = (tag_out == OWN_INSTR);
    assign data_rvalid_o  = (tag_out == OWN_DATA);
    assign instr_rdata_o  = ram_rdata_i;
    assign data_rdata_o   = ram_rdata_i;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Bench for jedro_1_mem_arbiter: three instances (RAM latency 1, 2, 3) share
// stimulus; a cycle-indexed grant history predicts grants and responses.
module tb_jedro_1_mem_arbiter;

    logic        clk;
    logic        rstn;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;

    logic        instr_gnt    [3];
    logic        instr_rvalid [3];
    logic [31:0] instr_rdata  [3];
    logic        data_gnt     [3];
    logic        data_rvalid  [3];
    logic [31:0] data_rdata   [3];
    logic        ram_en       [3];
    logic [3:0]  ram_we       [3];
    logic [31:0] ram_addr     [3];
    logic [31:0] ram_wdata    [3];
    logic [31:0] ram_rdata    [3];

    int          n_vec;
    int          n_err;
    int          cyc;
    int          last_own;
    bit          last_tie_data;
    int          own_hist [4096];
    bit          wr_hist  [4096];
    logic [31:0] dat_hist [4096];
    logic [31:0] ref_mem  [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g + 1;
        logic [31:0] mem  [256];
        logic [31:0] pipe [L];

        jedro_1_mem_arbiter #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .RAM_LATENCY (L)
        ) u_dut (
            .clk_i          (clk),
            .rstn_i         (rstn),
            .instr_req_i    (ireq),
            .instr_addr_i   (iaddr),
            .instr_gnt_o    (instr_gnt[g]),
            .instr_rvalid_o (instr_rvalid[g]),
            .instr_rdata_o  (instr_rdata[g]),
            .data_req_i     (dreq),
            .data_we_i      (dwe),
            .data_be_i      (dbe),
            .data_addr_i    (daddr),
            .data_wdata_i   (dwdata),
            .data_gnt_o     (data_gnt[g]),
            .data_rvalid_o  (data_rvalid[g]),
            .data_rdata_o   (data_rdata[g]),
            .ram_en_o       (ram_en[g]),
            .ram_we_o       (ram_we[g]),
            .ram_addr_o     (ram_addr[g]),
            .ram_wdata_o    (ram_wdata[g]),
            .ram_rdata_i    (ram_rdata[g])
        );

        assign ram_rdata[g] = pipe[L-1];

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            mem[0] = 32'h00000013;
            mem[1] = 32'h00100f93;
            mem[2] = 32'h40000f33;
        end

        // Simple synchronous RAM with an L-deep read pipeline
        always @(posedge clk) begin
            if (ram_en[g]) begin
                pipe[0] <= mem[ram_addr[g][9:2]];
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[g][b]) mem[ram_addr[g][9:2]][b*8 +: 8] <= ram_wdata[g][b*8 +: 8];
                end
            end else begin
                pipe[0] <= 32'hDEADBEEF;
            end
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic chk(input string tag, input int lat, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s lat=%0d cyc=%0d observed=%h expected=%h", tag, lat, cyc, obs, exp);
        end
    endtask

    // One clock cycle: predict from the rules, compare all instances, update model
    task automatic step();
        int eo;
        int idx;
        int po;
        int lat;
        @(negedge clk);
        if (!rstn) begin
            for (int j = 0; j < cyc; j++) own_hist[j] = 0;
            last_tie_data = 1'b0;
        end
        eo = 0;
        if (rstn) begin
            if (ireq && dreq) eo = last_tie_data ? 1 : 2;
            else if (ireq)    eo = 1;
            else if (dreq)    eo = 2;
        end
        own_hist[cyc] = eo;
        wr_hist[cyc]  = (eo == 2) && dwe;
        dat_hist[cyc] = (eo == 1) ? ref_mem[iaddr[9:2]] : ref_mem[daddr[9:2]];
        for (int g = 0; g < 3; g++) begin
            lat = g + 1;
            chk("instr_gnt", lat, 32'(instr_gnt[g]), 32'(eo == 1));
            chk("data_gnt",  lat, 32'(data_gnt[g]),  32'(eo == 2));
            chk("ram_en",    lat, 32'(ram_en[g]),    32'(eo != 0));
            chk("ram_we",    lat, 32'(ram_we[g]),    32'((eo == 2 && dwe) ? dbe : 4'b0000));
            if (eo == 1) chk("ram_addr_i", lat, ram_addr[g], iaddr);
            if (eo == 2) chk("ram_addr_d", lat, ram_addr[g], daddr);
            if (eo == 2 && dwe) chk("ram_wdata", lat, ram_wdata[g], dwdata);
            idx = cyc - lat;
            po  = (idx >= 0) ? own_hist[idx] : 0;
            chk("instr_rvalid", lat, 32'(instr_rvalid[g]), 32'(po == 1));
            chk("data_rvalid",  lat, 32'(data_rvalid[g]),  32'(po == 2));
            if (po == 1) chk("instr_rdata", lat, instr_rdata[g], dat_hist[idx]);
            if (po == 2 && !wr_hist[idx]) chk("data_rdata", lat, data_rdata[g], dat_hist[idx]);
        end
        if (ireq && dreq && eo != 0) last_tie_data = (eo == 2);
        if (eo == 2 && dwe) begin
            for (int b = 0; b < 4; b++) begin
                if (dbe[b]) ref_mem[daddr[9:2]][b*8 +: 8] = dwdata[b*8 +: 8];
            end
        end
        last_own = eo;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        ireq = 1'b0;
        dreq = 1'b0;
        dwe  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; last_own = 0; last_tie_data = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            own_hist[i] = 0; wr_hist[i] = 1'b0; dat_hist[i] = 32'h0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[0] = 32'h00000013;
        ref_mem[1] = 32'h00100f93;
        ref_mem[2] = 32'h40000f33;

        // Reset with both requests high: no grants, no enables
        rstn = 1'b0; ireq = 1'b1; dreq = 1'b1; dwe = 1'b1; dbe = 4'hF;
        iaddr = 32'h0; daddr = 32'h100; dwdata = 32'h12345678;
        step(); step(); step();

        // Fetch-only burst of three words
        rstn = 1'b1; dreq = 1'b0; dwe = 1'b0; ireq = 1'b1;
        iaddr = 32'h0; step();
        iaddr = 32'h4; step();
        iaddr = 32'h8; step();
        idle(4);

        // Four-cycle tie: data, instr, data, instr
        ireq = 1'b1; iaddr = 32'h4; dreq = 1'b1; dwe = 1'b0; daddr = 32'h8;
        step(); step(); step(); step();
        idle(4);

        // Byte write then read-back of the same word
        dreq = 1'b1; dwe = 1'b1; dbe = 4'b0010; daddr = 32'h100; dwdata = 32'hAABBCCDD;
        step();
        dwe = 1'b0; dbe = 4'b0000;
        step();
        idle(4);

        // Reset while a fetch is in flight; requests stay high during reset
        ireq = 1'b1; iaddr = 32'h8; step();
        rstn = 1'b0; step(); step();
        rstn = 1'b1; ireq = 1'b0;
        idle(4);

        // Mixed back-to-back: fetch, data read, idle, fetch
        ireq = 1'b1; iaddr = 32'h4; step();
        ireq = 1'b0; dreq = 1'b1; dwe = 1'b0; daddr = 32'h100; step();
        idle(1);
        ireq = 1'b1; iaddr = 32'h0; step();
        idle(5);

        // Random traffic, requests held until granted, occasional reset
        for (int n = 0; n < 600; n++) begin
            if (!ireq || last_own == 1) begin
                ireq  = ($urandom_range(0, 3) != 0);
                iaddr = 32'($urandom_range(0, 1023));
            end
            if (!dreq || last_own == 2) begin
                dreq   = ($urandom_range(0, 2) != 0);
                dwe    = 1'($urandom_range(0, 1));
                dbe    = 4'($urandom_range(0, 15));
                daddr  = 32'h100 + 32'($urandom_range(0, 255));
                dwdata = $urandom;
            end
            rstn = ($urandom_range(0, 63) != 0);
            step();
        end
        rstn = 1'b1;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
